// File: rtl/sseg_pkg.sv
// Shared constants and helpers for seven-segment display blocks.
// Segment patterns are active-high in g,f,e,d,c,b,a order (bit 6 = g, bit 0 = a);
// pins are inverted at the driver.
package sseg_pkg;

  // All segments and the decimal point dark on an active-low display.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Hex glyphs 0..F. Entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
  };

  // Map one nibble to its active-high g..a pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_TABLE[nibble];
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex-to-seven-segment decoder: nibble in, active-high g..a out.
// Kept as a separate block so other display drivers can reuse it.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = hex_to_seg(nibble);

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver.
// Data is captured into a pending register on load and committed to a shadow
// register only at frame boundaries, so a frame never mixes old and new digits.
// Each digit slot lasts DIV cycles; the first DEAD cycles are blank to avoid
// ghosting. Segment and digit-enable pins are active-low and registered.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter int DEAD     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  blank_lz,
  input  logic                  load,
  input  logic                  enable,
  output logic [7:0]            sseg,
  output logic [N_DIGITS-1:0]   en_dig,
  output logic                  frame_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PC_W  = $clog2(DIV);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DIV - 1);
  localparam logic [PC_W-1:0]  PC_DEAD  = PC_W'(DEAD);

  // Scan position
  logic [PC_W-1:0]  pc;
  logic [IDX_W-1:0] idx;

  // Data captured by load, waiting for the next frame boundary
  logic [4*N_DIGITS-1:0] pend_value;
  logic [N_DIGITS-1:0]   pend_dp;
  logic                  pend_blz;

  // Data currently on display
  logic [4*N_DIGITS-1:0] shd_value;
  logic [N_DIGITS-1:0]   shd_dp;
  logic                  shd_blz;

  // Scan events
  logic slot_end;
  logic boundary;

  // Current-digit view of the shadow register
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic                lz_run;
  logic                blank_cur;
  logic [N_DIGITS-1:0] dig_sel;
  logic [6:0]          cur_pat;

  assign slot_end = enable && (pc == PC_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  // Prescaler and digit index; both held at zero while the display is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      idx <= '0;
    end else if (!enable) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      pc  <= '0;
      idx <= '0;
    end else if (slot_end) begin
      pc  <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      pc <= pc + PC_W'(1);
    end
  end

  // Pending register: the last load before a boundary wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these data registers are small and must come up blank, so they
      // are reset explicitly rather than left to power-up state.
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blz   <= 1'b0;
    end else if (load) begin
      pend_value <= value;
      pend_dp    <= dp;
      pend_blz   <= blank_lz;
    end
  end

  // Shadow register: tracks pending while dark, otherwise commits at frame
  // boundaries; a load on the boundary cycle bypasses straight to the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_value <= '0;
      shd_dp    <= '0;
      shd_blz   <= 1'b0;
    end else if (!enable) begin
      shd_value <= pend_value;
      shd_dp    <= pend_dp;
      shd_blz   <= pend_blz;
    end else if (boundary) begin
      shd_value <= load ? value    : pend_value;
      shd_dp    <= load ? dp       : pend_dp;
      shd_blz   <= load ? blank_lz : pend_blz;
    end
  end

  // Frame pulse one cycle after the wrap from the last digit to digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
    end
  end

  // Select the current digit's nibble/dp and track the leading-zero run from
  // the most significant digit down to the current one.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    lz_run  = 1'b1;
    dig_sel = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (shd_value[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        cur_nib    = shd_value[4*i +: 4];
        cur_dp     = shd_dp[i];
        cur_lz     = lz_run;
        dig_sel[i] = 1'b1;
      end
    end
  end

  // Digit 0 always shows, even when the whole value is zero.
  assign blank_cur = shd_blz && cur_lz && (idx != '0);

  sseg_hex_decode u_hex_decode (
    .nibble  (cur_nib),
    .pattern (cur_pat)
  );

  // Registered pins: dark during dead time or when disabled; a blanked digit
  // keeps its decimal point and enables the digit only if that point is lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sseg   <= SEG_OFF;
      en_dig <= '1;
    end else if (!enable || (pc < PC_DEAD)) begin
      sseg   <= SEG_OFF;
      en_dig <= '1;
    end else if (blank_cur) begin
      sseg   <= {~cur_dp, 7'h7F};
      en_dig <= cur_dp ? ~dig_sel : '1;
    end else begin
      sseg   <= ~{cur_dp, cur_pat};
      en_dig <= ~dig_sel;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with N_DIGITS=4, DIV=8, DEAD=2.
// Inputs change and outputs are sampled on the falling edge. Cycle k counts
// falling edges after reset release; outputs seen at cycle k reflect the scan
// position m=k-1, i.e. pc = m % 8 and idx = (m / 8) % 4 while enabled.
module tb_sseg_scan_driver;

  localparam int N_DIGITS = 4;
  localparam int DIV      = 8;
  localparam int DEAD     = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp;
  logic                  blank_lz;
  logic                  load;
  logic                  enable;
  logic [7:0]            sseg;
  logic [N_DIGITS-1:0]   en_dig;
  logic                  frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int now      = 0;

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .N_DIGITS (N_DIGITS),
    .DIV      (DIV),
    .DEAD     (DEAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .load       (load),
    .enable     (enable),
    .sseg       (sseg),
    .en_dig     (en_dig),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] en_exp, input logic [7:0] seg_exp);
    check({tag, ".en_dig"}, {4'h0, en_dig}, {4'h0, en_exp});
    check({tag, ".sseg"}, sseg, seg_exp);
  endtask

  task automatic check_fd(input string tag, input logic exp);
    check({tag, ".frame_done"}, {7'h0, frame_done}, {7'h0, exp});
  endtask

  // Advance to falling edge number k (absolute, since reset release).
  task automatic goto(input int k);
    while (now < k) begin
      @(negedge clk);
      now++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    load     = 1'b0;
    value    = '0;
    dp       = '0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check_out("reset", 4'hF, 8'hFF);
    check_fd("reset", 1'b0);

    // Cycle 0: release reset, load 1234, start scanning.
    rst_n    = 1'b1;
    value    = 16'h1234;
    dp       = 4'b0000;
    blank_lz = 1'b0;
    load     = 1'b1;
    enable   = 1'b1;
    now      = 0;
    goto(1);
    load = 1'b0;

    // Frame 0 still shows the reset shadow (all zeros, no blanking).
    goto(31);  check_fd("pre_wrap0", 1'b0);
    goto(32);  check_fd("wrap0", 1'b1);
               check_out("f0_d3", 4'h7, 8'hC0);
    goto(33);  check_fd("post_wrap0", 1'b0);
               check_out("f1_d0_dead0", 4'hF, 8'hFF);
    goto(34);  check_out("f1_d0_dead1", 4'hF, 8'hFF);
    goto(35);  check_out("f1_d0", 4'hE, 8'h99);
    goto(57);  check_out("f1_d3_dead0", 4'hF, 8'hFF);
    goto(59);  check_out("f1_d3", 4'h7, 8'hF9);
    goto(63);  check_fd("pre_wrap1", 1'b0);
    goto(64);  check_fd("wrap1", 1'b1);
    goto(65);  check_fd("post_wrap1", 1'b0);

    // Load 0050 with blanking mid-frame; current frame keeps 1234.
    goto(70);
    value    = 16'h0050;
    dp       = 4'b0100;
    blank_lz = 1'b1;
    load     = 1'b1;
    goto(71);
    load = 1'b0;
    goto(75);  check_out("f2_d1_old", 4'hD, 8'hB0);
    goto(96);  check_fd("wrap2", 1'b1);

    // Frame 3: blanked display of 0050 with dp on digit 2.
    goto(99);  check_out("lz_d0", 4'hE, 8'hC0);
    goto(100);
    value    = 16'hAAAA;
    dp       = 4'b0000;
    blank_lz = 1'b0;
    load     = 1'b1;
    goto(101);
    load = 1'b0;
    goto(107); check_out("lz_d1", 4'hD, 8'h92);
    goto(113);
    value = 16'h5555;
    load  = 1'b1;
    goto(114);
    load = 1'b0;
    goto(115); check_out("lz_d2_dp", 4'hB, 8'h7F);
    goto(123); check_out("lz_d3_dark", 4'hF, 8'hFF);

    // Frame 4: last load (5555) wins.
    goto(131); check_out("f4_d0", 4'hE, 8'h92);
    goto(155); check_out("f4_d3", 4'h7, 8'h92);

    // Load exactly on the boundary cycle goes straight to the shadow.
    goto(159);
    value = 16'h0007;
    load  = 1'b1;
    goto(160);
    load = 1'b0;
    check_fd("wrap4", 1'b1);
    goto(163); check_out("bypass_d0", 4'hE, 8'hF8);
    goto(187); check_out("bypass_d3", 4'h7, 8'hC0);

    // Drop enable mid-slot.
    goto(190); check_out("pre_disable", 4'h7, 8'hC0);
    enable = 1'b0;
    goto(191); check_out("disabled", 4'hF, 8'hFF);
               check_fd("disabled", 1'b0);
    goto(193);
    value = 16'hFFFF;
    load  = 1'b1;
    goto(194);
    load = 1'b0;
    goto(196); check_out("disabled_load", 4'hF, 8'hFF);
               check_fd("disabled_load", 1'b0);

    // Re-enable: digit 0 appears DEAD+1 cycles later with fresh data.
    goto(200);
    enable = 1'b1;
    goto(202); check_out("reen_dead", 4'hF, 8'hFF);
    goto(203); check_out("reen_d0", 4'hE, 8'h8E);
    goto(212); check_out("reen_d1", 4'hD, 8'h8E);

    // Asynchronous reset mid-slot, checked without any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'hF, 8'hFF);
    check_fd("async_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_out("restart_dead", 4'hF, 8'hFF);
    @(negedge clk);
    check_out("restart_d0", 4'hE, 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
